sdp_asym_bram_ctl: RTL
======================

// Module: sdp_asym_bram_ctl
// PURPOSE
//   Parametrised simple-dual-port asymmetric block RAM with one wide and one narrow port.
//   The wide side is 2**RLOG2 narrow lanes and is selectable as either the read side or the write side.
//   Adds per-lane write enables, a read enable, an optional output register, a valid flag,
//   and a post-reset zero-fill sweep.
//   Inferred onto QL block RAM via syn_ramstyle="block_ram"; used as the BRAM inference formal/sim target.
// PARAMETERS
//   ABITS      10  narrow-side address width; DEPTH = 2**ABITS narrow words
//   DBITS      8   narrow word width
//   RLOG2      2   log2 width ratio; R = 2**RLOG2 lanes per wide word (1..3)
//   WIDE_WR    0   0: narrow write / wide read; 1: wide write / narrow read
//   OUTREG     0   1: add a second read pipeline register (latency 2)
//   INIT_CLR   1   1: zero-fill the memory after reset; 0: no sweep (contents undefined)
// PORTS
//   clk       in   1                     clock, all logic on rising edge
//   rst       in   1                     synchronous reset, active-high
//   we        in   1                     write enable
//   wa        in   WIDE_WR?ABITS-RLOG2:ABITS   write address
//   wd        in   WIDE_WR?R*DBITS:DBITS       write data
//   wbe       in   WIDE_WR?R:1                 per-lane write enable (ANDed with we)
//   re        in   1                     read enable
//   ra        in   WIDE_WR?ABITS:ABITS-RLOG2   read address
//   rd        out  WIDE_WR?DBITS:R*DBITS       read data
//   rd_valid  out  1                     rd holds data for an accepted read
//   busy      out  1                     zero-fill sweep in progress; we/re ignored
// BEHAVIOUR
//   - Lane map: wide address A, lane k <-> narrow address {A, k[RLOG2-1:0]}.
//     Lane k sits at bits [(k+1)*DBITS-1 : k*DBITS].
//   - Reset (rst=1 at edge): rd=0, rd_valid=0, pipeline regs=0, sweep counter=0.
//     Writes/reads presented while rst=1 are discarded. Memory is not touched by rst itself.
//   - FSM states:
//     - CLEAR (entered from reset when INIT_CLR=1):
//       - busy=1; each cycle writes all R lanes of wide word cnt with 0, then cnt++.
//       - After writing word 2**(ABITS-RLOG2)-1 -> READY. Sweep takes 2**(ABITS-RLOG2) cycles.
//     - READY (entered from reset when INIT_CLR=0): busy=0; user ports live.
//     - rst in any state returns to the reset state; a partial sweep restarts from 0.
//   - Write: in READY, at an edge with we=1, lane k of addr wa is written with wd lane k iff wbe[k]=1.
//     Narrow-write mode: whole word written when we&wbe[0].
//   - Read: in READY, re=1 at edge N samples mem[ra].
//     - OUTREG=0: rd/rd_valid update at edge N (visible cycle N+1).
//     - OUTREG=1: update one edge later.
//   - re=0: rd holds its last value; rd_valid=0 for that slot. rd_valid is per-read, never sticky.
//   - Collision (same narrow word written and read at the same edge): read-first, rd returns the old value.
//     Lanes of a wide access not being written return new-independent stored data.
//   - busy=1: re treated as 0 (rd_valid=0, rd holds); we ignored.
//   - Address wrap: none; all addresses in range by width.
//   - Latency constant: 1+OUTREG cycles; full throughput, one read and one write per cycle.
// TESTING (ABITS=6, DBITS=8, RLOG2=2 unless noted)
//   1. rst 1 cycle, INIT_CLR=1:
//      - busy high exactly 16 cycles then low.
//      - Read of all 16 wide words -> rd=32'h0 each, rd_valid=1 one cycle after each re.
//   2. WIDE_WR=0: write 8'hA0..8'hA3 to wa=4..7, then re ra=1
//      -> rd=32'hA3A2A1A0 next cycle. With OUTREG=1 it appears one cycle later.
//   3. WIDE_WR=1: we, wa=3, wd=32'h44332211, wbe=4'b0101; then read ra=12..15
//      -> 8'h11, 8'h00, 8'h33, 8'h00.
//   4. Collision, WIDE_WR=0: mem[9]=8'h55.
//      Same edge we wa=9 wd=8'hEE and re ra=2 -> rd[15:8]=8'h55; repeat read -> rd[15:8]=8'hEE.
//   5. rst asserted at sweep cycle 7 with we=1 presented
//      -> sweep restarts (busy 16 more cycles); write discarded, location reads 0.
//   6. re=0 for 3 cycles after a read of 32'hCAFEBABE -> rd stays 32'hCAFEBABE, rd_valid=0.

Source files
------------

// File: rtl/sdp_asym_bram_ctl.sv
// Simple-dual-port asymmetric block RAM: one wide port (2**RLOG2 lanes) and one narrow port,
// with per-lane write enables, registered read path and a post-reset zero-fill sweep.
//
// state | meaning
// CLEAR | zero-fill sweep, one wide word per cycle; user ports ignored, busy=1
// READY | user read/write ports live, busy=0
module sdp_asym_bram_ctl #(
  parameter int ABITS    = 10,
  parameter int DBITS    = 8,
  parameter int RLOG2    = 2,
  parameter int WIDE_WR  = 0,
  parameter int OUTREG   = 0,
  parameter int INIT_CLR = 1,
  localparam int R       = 2 ** RLOG2,
  localparam int WABITS  = ABITS - RLOG2,
  localparam int WA_W    = (WIDE_WR != 0) ? WABITS : ABITS,
  localparam int WD_W    = (WIDE_WR != 0) ? R * DBITS : DBITS,
  localparam int WBE_W   = (WIDE_WR != 0) ? R : 1,
  localparam int RA_W    = (WIDE_WR != 0) ? ABITS : WABITS,
  localparam int RD_W    = (WIDE_WR != 0) ? DBITS : R * DBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WA_W-1:0]  wa,
  input  logic [WD_W-1:0]  wd,
  input  logic [WBE_W-1:0] wbe,
  input  logic             re,
  input  logic [RA_W-1:0]  ra,
  output logic [RD_W-1:0]  rd,
  output logic             rd_valid,
  output logic             busy
);

  localparam int WDEPTH = 2 ** WABITS;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [WABITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_CLR != 0) ? CLEAR : READY;
      busy  <= (INIT_CLR != 0);
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + WABITS'(1);
          if (cnt == '1) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  logic              clearing;
  logic              ready;
  logic [WABITS-1:0] w_word;
  logic [WABITS-1:0] r_word;
  logic [WABITS-1:0] mem_wa;
  logic [R-1:0]      user_we;
  logic [R-1:0]      lane_we;
  logic [DBITS-1:0]  lane_wd [R];
  logic [DBITS-1:0]  lane_q  [R];
  logic [RD_W-1:0]   rd_word;

  assign clearing = (state == CLEAR);
  assign ready    = (state == READY);

  // Address/lane mapping differs by which side is wide: narrow address = {wide address, lane}.
  if (WIDE_WR != 0) begin : g_wide_wr
    logic [RLOG2-1:0] r_lane;
    assign w_word  = wa;
    assign r_word  = ra[ABITS-1:RLOG2];
    assign r_lane  = ra[RLOG2-1:0];
    assign rd_word = lane_q[r_lane];
    for (genvar k = 0; k < R; k++) begin : g_lane
      assign user_we[k] = we & wbe[k];
      assign lane_wd[k] = wd[k*DBITS +: DBITS];
    end
  end else begin : g_narrow_wr
    assign w_word = wa[ABITS-1:RLOG2];
    assign r_word = ra;
    for (genvar k = 0; k < R; k++) begin : g_lane
      assign user_we[k] = we & wbe[0] & (wa[RLOG2-1:0] == RLOG2'(k));
      assign lane_wd[k] = wd;
      assign rd_word[k*DBITS +: DBITS] = lane_q[k];
    end
  end

  assign mem_wa = clearing ? cnt : w_word;

  // One narrow-wide RAM per lane; the read samples the old contents on a same-edge write.
  for (genvar k = 0; k < R; k++) begin : g_mem
    (* syn_ramstyle = "block_ram" *) logic [DBITS-1:0] mem [WDEPTH];

    assign lane_we[k] = ~rst & (clearing | (ready & user_we[k]));

    always_ff @(posedge clk) begin
      if (lane_we[k]) mem[mem_wa] <= clearing ? '0 : lane_wd[k];
    end

    assign lane_q[k] = mem[r_word];
  end

  logic            re_acc;
  logic [RD_W-1:0] s1_d;
  logic            s1_v;

  assign re_acc = re & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_d <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= re_acc;
      if (re_acc) s1_d <= rd_word;
    end
  end

  if (OUTREG != 0) begin : g_outreg
    always_ff @(posedge clk) begin
      if (rst) begin
        rd       <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= s1_v;
        if (s1_v) rd <= s1_d;
      end
    end
  end else begin : g_no_outreg
    assign rd       = s1_d;
    assign rd_valid = s1_v;
  end

endmodule
